// File: rtl/cell_mem_sequencer_pkg.sv
// Shared types and defaults for the cell memory sequencer: state encoding,
// output strobe bundle and the state-to-strobe decode.
package cell_mem_sequencer_pkg;

  localparam int SIZE_DEF   = 5;
  localparam int CELLS_DEF  = 25;
  localparam int ROUNDS_DEF = 24;
  localparam int RW_DEF     = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic init;
    logic firstread;
    logic read;
    logic write;
    logic ok;
    logic calc_req;
    logic busy;
    logic done;
  } strobes_t;

  function automatic strobes_t decode_strobes(input state_e st, input logic round_zero);
    strobes_t s;
    s = '0;
    case (st)
      IDLE:    s = '0;
      LOAD:    begin s.init = 1'b1; s.busy = 1'b1; end
      READ:    begin
        s.read      = 1'b1;
        s.calc_req  = 1'b1;
        s.firstread = round_zero;
        s.busy      = 1'b1;
      end
      WRITE:   begin s.write = 1'b1; s.busy = 1'b1; end
      COMMIT:  begin s.ok    = 1'b1; s.busy = 1'b1; end
      DONE:    begin s.done  = 1'b1; s.busy = 1'b1; end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cell_mem_sequencer_counter.sv
// Cell index / round counters for the sequencer; index wraps at CELLS-1 and
// round saturates at ROUNDS-1.
module cell_round_counter
  import cell_mem_sequencer_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int CELLS  = CELLS_DEF,
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int RW     = RW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            next_round_i,
  output logic [SIZE-1:0] index_o,
  output logic [RW-1:0]   round_o,
  output logic            last_cell_o,
  output logic            last_round_o
);

  localparam logic [SIZE-1:0] LAST_IDX   = SIZE'(CELLS - 1);
  localparam logic [RW-1:0]   LAST_ROUND = RW'(ROUNDS - 1);

  logic [SIZE-1:0] index_q, index_d;
  logic [RW-1:0]   round_q, round_d;

  assign last_cell_o  = (index_q == LAST_IDX);
  assign last_round_o = (round_q == LAST_ROUND);
  assign index_o      = index_q;
  assign round_o      = round_q;

  // Counter next-state: clear wins, then cell advance, then round advance.
  always_comb begin
    index_d = index_q;
    round_d = round_q;
    if (clr_i) begin
      index_d = '0;
      round_d = '0;
    end else if (inc_i) begin
      if (last_cell_o) begin
        index_d = '0;
      end else begin
        index_d = index_q + SIZE'(1);
      end
    end else if (next_round_i && !last_round_o) begin
      round_d = round_q + RW'(1);
    end else begin
      index_d = index_q;
      round_d = round_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      round_q <= '0;
    end else begin
      index_q <= index_d;
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/cell_mem_sequencer.sv
// Moore FSM sequencing a cell memory block through LOAD, per-cell READ/WRITE
// with a compute handshake, a per-round COMMIT and a final DONE pulse.
module cell_mem_sequencer
  import cell_mem_sequencer_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int CELLS  = CELLS_DEF,
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int RW     = RW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            calc_ack_i,
  output logic            init_o,
  output logic            firstread_o,
  output logic            read_o,
  output logic            write_o,
  output logic            ok_o,
  output logic            calc_req_o,
  output logic [SIZE-1:0] index_o,
  output logic [RW-1:0]   round_o,
  output logic            busy_o,
  output logic            done_o
);

  state_e   state_q, state_d;
  strobes_t strobes_q, strobes_d;
  logic     clr_s, inc_s, next_round_s;
  logic     last_cell_s, last_round_s;
  logic     round_zero_d;

  cell_round_counter #(
    .SIZE   (SIZE),
    .CELLS  (CELLS),
    .ROUNDS (ROUNDS),
    .RW     (RW)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_s),
    .inc_i        (inc_s),
    .next_round_i (next_round_s),
    .index_o      (index_o),
    .round_o      (round_o),
    .last_cell_o  (last_cell_s),
    .last_round_o (last_round_s)
  );

  // Next-state and counter control; abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    clr_s        = 1'b0;
    inc_s        = 1'b0;
    next_round_s = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        IDLE:    state_d = start_i ? LOAD : IDLE;
        LOAD:    begin state_d = READ; clr_s = 1'b1; end
        READ:    state_d = calc_ack_i ? WRITE : READ;
        WRITE:   begin
          inc_s   = 1'b1;
          state_d = last_cell_s ? COMMIT : READ;
        end
        COMMIT:  begin
          if (last_round_s) begin
            state_d = DONE;
          end else begin
            state_d      = READ;
            next_round_s = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Round-zero flag as it will be after this edge, so firstread can be registered.
  always_comb begin
    if (state_q == LOAD) begin
      round_zero_d = 1'b1;
    end else if (state_q == COMMIT) begin
      round_zero_d = 1'b0;
    end else begin
      round_zero_d = (round_o == '0);
    end
    strobes_d = decode_strobes(state_d, round_zero_d);
  end

  // State and output strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      strobes_q <= '0;
    end else begin
      state_q   <= state_d;
      strobes_q <= strobes_d;
    end
  end

  assign init_o      = strobes_q.init;
  assign firstread_o = strobes_q.firstread;
  assign read_o      = strobes_q.read;
  assign write_o     = strobes_q.write;
  assign ok_o        = strobes_q.ok;
  assign calc_req_o  = strobes_q.calc_req;
  assign busy_o      = strobes_q.busy;
  assign done_o      = strobes_q.done;

endmodule

// File: tb/tb_cell_mem_sequencer.sv
// Directed bench: two sequencers (ROUNDS=1 and ROUNDS=2) share stimulus; a
// scoreboard queue holds the expected {round,index} of every write.
module tb_cell_mem_sequencer;

  localparam int CELLS = 25;

  logic clk = 1'b0;
  logic rst, start, abort, ack;

  logic       a_init, a_fr, a_read, a_write, a_ok, a_req, a_busy, a_done;
  logic [4:0] a_index, a_round;
  logic       b_init, b_fr, b_read, b_write, b_ok, b_req, b_busy, b_done;
  logic [4:0] b_index, b_round;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int ok_cnt_a = 0, ok_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int rd_cnt_b = 0, fr_cnt_b = 0, wr_cnt_a = 0;
  int done_cyc_a = 0, done_cyc_b = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;

  cell_mem_sequencer #(.SIZE(5), .CELLS(CELLS), .ROUNDS(1), .RW(5)) dut_a (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .calc_ack_i(ack),
    .init_o(a_init), .firstread_o(a_fr), .read_o(a_read), .write_o(a_write),
    .ok_o(a_ok), .calc_req_o(a_req), .index_o(a_index), .round_o(a_round),
    .busy_o(a_busy), .done_o(a_done));

  cell_mem_sequencer #(.SIZE(5), .CELLS(CELLS), .ROUNDS(2), .RW(5)) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .calc_ack_i(ack),
    .init_o(b_init), .firstread_o(b_fr), .read_o(b_read), .write_o(b_write),
    .ok_o(b_ok), .calc_req_o(b_req), .index_o(b_index), .round_o(b_round),
    .busy_o(b_busy), .done_o(b_done));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes_b();
    return {24'd0, b_init, b_fr, b_read, b_write, b_ok, b_req, b_busy, b_done};
  endfunction

  function automatic logic [31:0] strobes_a();
    return {24'd0, a_init, a_fr, a_read, a_write, a_ok, a_req, a_busy, a_done};
  endfunction

  function automatic logic [31:0] pos(input int r, input int i);
    return 32'(r) * 32'd256 + 32'(i);
  endfunction

  // Monitor: one-hot invariant, firstread rule, write scoreboard, event counters.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot_a", {31'd0, $countones({a_init, a_read, a_write, a_ok, a_done}) <= 1}, 32'd1);
      check("onehot_b", {31'd0, $countones({b_init, b_read, b_write, b_ok, b_done}) <= 1}, 32'd1);
      if (b_read) begin
        check("firstread_b", {31'd0, b_fr}, {31'd0, b_round == 5'd0});
        rd_cnt_b <= rd_cnt_b + 1;
        if (b_fr) fr_cnt_b <= fr_cnt_b + 1;
      end
      if (b_write) begin
        if (exp_q.size() == 0) begin
          check("write_unexpected", pos(int'(b_round), int'(b_index)), 32'hFFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("write_pos", pos(int'(b_round), int'(b_index)), exp_e);
        end
      end
      if (a_write) wr_cnt_a <= wr_cnt_a + 1;
      if (a_ok) ok_cnt_a <= ok_cnt_a + 1;
      if (b_ok) ok_cnt_b <= ok_cnt_b + 1;
      if (a_done) begin done_cnt_a <= done_cnt_a + 1; done_cyc_a <= cyc; end
      if (b_done) begin done_cnt_b <= done_cnt_b + 1; done_cyc_b <= cyc; end
    end
  end

  initial begin
    int k, t, ok0a, ok0b, dn0a, dn0b, rd0, fr0, wr0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_strobes_a", strobes_a(), 32'd0);
    check("reset_strobes_b", strobes_b(), 32'd0);
    check("reset_pos_b", pos(int'(b_round), int'(b_index)), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full job with ack tied high; a stray start mid-job must be ignored.
    ok0a = ok_cnt_a; ok0b = ok_cnt_b; dn0a = done_cnt_a; dn0b = done_cnt_b;
    rd0 = rd_cnt_b; fr0 = fr_cnt_b; wr0 = wr_cnt_a;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < CELLS; i++) exp_q.push_back(pos(r, i));
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("load_a", strobes_a(), 32'h82);
    check("load_b", strobes_b(), 32'h82);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (done_cnt_b == dn0b && t < 300) begin @(negedge clk); t++; end
    check("job1_timeout", {31'd0, t < 300}, 32'd1);
    @(negedge clk);
    // Cycle after edge n is numbered n+1; done expected in cycle k+1+R*(2*CELLS+1)+1.
    check("latency_a", 32'(done_cyc_a + 1 - k), 32'd53);
    check("latency_b", 32'(done_cyc_b + 1 - k), 32'd104);
    check("ok_count_a", 32'(ok_cnt_a - ok0a), 32'd1);
    check("ok_count_b", 32'(ok_cnt_b - ok0b), 32'd2);
    check("done_count_a", 32'(done_cnt_a - dn0a), 32'd1);
    check("done_count_b", 32'(done_cnt_b - dn0b), 32'd1);
    check("write_count_a", 32'(wr_cnt_a - wr0), 32'd25);
    check("read_count_b", 32'(rd_cnt_b - rd0), 32'd50);
    check("firstread_count_b", 32'(fr_cnt_b - fr0), 32'd25);
    check("queue_empty_job1", 32'(exp_q.size()), 32'd0);
    check("idle_after_done_b", strobes_b(), 32'd0);
    check("hold_pos_b", pos(int'(b_round), int'(b_index)), pos(1, 0));

    // Delayed ack on index 4, then abort during WRITE at index 12.
    ok0b = ok_cnt_b; dn0b = done_cnt_b;
    for (int i = 0; i <= 12; i++) exp_q.push_back(pos(0, i));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(b_write && b_index == 5'd3) && t < 100) begin @(negedge clk); t++; end
    check("wait_write3_timeout", {31'd0, t < 100}, 32'd1);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_read_req", {29'd0, b_read, b_req, b_write}, 32'd6);
      check("held_index", {27'd0, b_index}, 32'd4);
      if (i == 3) ack = 1'b1;
    end
    @(negedge clk);
    check("write_after_ack", {30'd0, b_write, b_read}, 32'd2);
    check("write_after_ack_idx", {27'd0, b_index}, 32'd4);
    @(negedge clk);
    check("next_read_idx", {26'd0, b_read, b_index}, 32'h25);
    t = 0;
    while (!(b_write && b_index == 5'd12) && t < 100) begin @(negedge clk); t++; end
    check("wait_write12_timeout", {31'd0, t < 100}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_strobes_b", strobes_b(), 32'd0);
    check("abort_pos_b", pos(int'(b_round), int'(b_index)), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_ok", 32'(ok_cnt_b - ok0b), 32'd0);
    check("abort_no_done", 32'(done_cnt_b - dn0b), 32'd0);
    check("queue_empty_abort", 32'(exp_q.size()), 32'd0);

    // abort together with start in IDLE keeps the block idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", strobes_b(), 32'd0);

    // Restart, then asynchronous reset while reading index 7.
    for (int i = 0; i < 7; i++) exp_q.push_back(pos(0, i));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_load", {26'd0, b_init, b_index}, 32'h20);
    t = 0;
    while (!(b_read && b_index == 5'd7) && t < 100) begin @(negedge clk); t++; end
    check("wait_read7_timeout", {31'd0, t < 100}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_strobes", strobes_b(), 32'd0);
    check("async_rst_pos", pos(int'(b_round), int'(b_index)), 32'd0);
    @(negedge clk);
    check("rst_hold_strobes", strobes_b(), 32'd0);
    check("queue_empty_rst", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
